// File: rtl/serial_deser_sync_if.sv
// serial_deser_sync_if: serial input, word output and status bundle for
// serial_deser_sync. The master side feeds bits and acknowledges words;
// the slave side is the deserializer.
interface serial_deser_sync_if #(
  parameter int unsigned WIDTH = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             out_ack;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             locked;
  logic             overrun;
  logic [7:0]       word_cnt;

  modport master (
    output bit_in, bit_valid, out_ack,
    input  out_data, out_valid, locked, overrun, word_cnt
  );

  modport slave (
    input  bit_in, bit_valid, out_ack,
    output out_data, out_valid, locked, overrun, word_cnt
  );
endinterface

// File: rtl/serial_deser_sync.sv
// serial_deser_sync: frame-synchronising serial-to-parallel converter.
// Hunts for the WIDTH-bit SYNC pattern (MSB-first), then shifts in data bits
// MSB-first and presents completed words on a valid/ack handshake with a
// sticky overrun flag and a modulo-256 loaded-word counter.
// Optional feature macro: SERDES_CONT_EN
//   defined   -> continuous mode, stays locked after each word
//   undefined -> single-word mode, every word needs its own SYNC
module serial_deser_sync #(
  parameter int unsigned           WIDTH = 8,
  parameter logic [WIDTH-1:0]      SYNC  = WIDTH'(8'hA5)
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     sync_clr,
  serial_deser_sync_if.slave       bus
);

  localparam int unsigned FW = $clog2(WIDTH + 1);
  localparam int unsigned BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH);
  localparam logic [FW-1:0] FILL_THR = FW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic {
    S_HUNT,
    S_COLLECT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [FW-1:0]    r_fill;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_locked;
  logic             r_overrun;
  logic [7:0]       r_word_cnt;

  logic [WIDTH-1:0] w_next_sr;
  logic             w_sync_hit;
  logic             w_word_done;

  // Candidate shift-register contents and the two events they can produce
  always_comb begin
    w_next_sr   = {r_sr[WIDTH-2:0], bus.bit_in};
    w_sync_hit  = bus.bit_valid && (r_state == S_HUNT) &&
                  (r_fill >= FILL_THR) && (w_next_sr == SYNC);
    w_word_done = bus.bit_valid && (r_state == S_COLLECT) &&
                  (r_bitcnt == BIT_LAST);
  end

  // Sync-hunt / collect FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_HUNT;
      r_sr        <= '0;
      r_fill      <= '0;
      r_bitcnt    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_overrun   <= 1'b0;
      r_word_cnt  <= '0;
    end else if (sync_clr) begin
      r_state     <= S_HUNT;
      r_sr        <= '0;
      r_fill      <= '0;
      r_bitcnt    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_overrun   <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      if (bus.bit_valid) begin
        r_sr <= w_next_sr;
        case (r_state)
          S_HUNT: begin
            if (r_fill != FILL_MAX) begin
              r_fill <= r_fill + FW'(1);
            end
            if (w_sync_hit) begin
              r_state  <= S_COLLECT;
              r_locked <= 1'b1;
              r_bitcnt <= '0;
            end
          end
          S_COLLECT: begin
            if (r_bitcnt == BIT_LAST) begin
              r_bitcnt <= '0;
`ifdef SERDES_CONT_EN
              r_state  <= S_COLLECT;
`else
              // Back to hunting; fill restarts so stale data cannot fake a SYNC
              r_state  <= S_HUNT;
              r_locked <= 1'b0;
              r_fill   <= '0;
`endif
            end else begin
              r_bitcnt <= r_bitcnt + BW'(1);
            end
          end
          default: begin
            r_state  <= S_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end

      // Output stage: completion with free slot loads, otherwise drop and flag
      if (w_word_done) begin
        if (!r_out_valid || bus.out_ack) begin
          r_out_data  <= w_next_sr;
          r_out_valid <= 1'b1;
          r_word_cnt  <= r_word_cnt + 8'd1;
        end else begin
          r_overrun   <= 1'b1;
        end
      end else if (r_out_valid && bus.out_ack) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.locked    = r_locked;
  assign bus.overrun   = r_overrun;
  assign bus.word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_serial_deser_sync.sv
// tb_serial_deser_sync: directed scoreboard bench for serial_deser_sync.
// u0 uses SYNC=8'hA5, u1 uses SYNC=8'h00 for the reset-contents false-match case.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_deser_sync;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic Reset;
  logic clr0;
  logic clr1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exp_t       exp_q[$];
  logic [7:0] prev_cnt = 8'd0;

  serial_deser_sync_if #(.WIDTH(8)) bus0 ();
  serial_deser_sync_if #(.WIDTH(8)) bus1 ();

  serial_deser_sync #(.WIDTH(8), .SYNC(8'hA5)) u0 (
    .clk      (clk),
    .Reset    (Reset),
    .sync_clr (clr0),
    .bus      (bus0.slave)
  );

  serial_deser_sync #(.WIDTH(8), .SYNC(8'h00)) u1 (
    .clk      (clk),
    .Reset    (Reset),
    .sync_clr (clr1),
    .bus      (bus1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input logic ack, input bit gap);
    bus0.bit_in    = b;
    bus0.bit_valid = 1'b1;
    bus0.out_ack   = ack;
    @(negedge clk);
    bus0.bit_valid = 1'b0;
    bus0.out_ack   = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ack_last, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], (i == 0) ? ack_last : 1'b0, gap);
    end
  endtask

  task automatic do_clr0();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
  endtask

  task automatic do_ack();
    bus0.out_ack = 1'b1;
    @(negedge clk);
    bus0.out_ack = 1'b0;
  endtask

  // Scoreboard monitor: each newly loaded word must match the next expected entry
  always @(negedge clk) begin
    if (bus0.word_cnt === prev_cnt + 8'd1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data %0h cnt %0d, expected no word", bus0.out_data, bus0.word_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus0.out_data !== e.data || bus0.word_cnt !== e.cnt || bus0.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL word: got data %0h cnt %0d valid %0b expected data %0h cnt %0d valid 1",
                   bus0.out_data, bus0.word_cnt, bus0.out_valid, e.data, e.cnt);
        end
      end
    end
    prev_cnt = bus0.word_cnt;
  end

  initial begin
    logic [7:0] v;
    Reset = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0;
    bus0.bit_in = 1'b0; bus0.bit_valid = 1'b0; bus0.out_ack = 1'b0;
    bus1.bit_in = 1'b0; bus1.bit_valid = 1'b0; bus1.out_ack = 1'b0;
    #1 Reset = 1'b0;

    // 1. reset for three cycles, all outputs zero, then lock on A5
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_data", 32'(bus0.out_data), 32'h0);
      chk("rst_flags", {28'h0, bus0.out_valid, bus0.locked, bus0.overrun, 1'b0}, 32'h0);
      chk("rst_word_cnt", 32'(bus0.word_cnt), 32'h0);
    end
    Reset = 1'b1;
    @(negedge clk);
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0, 0);
    chk("lock_after7", 32'(bus0.locked), 32'h0);
    send_bit(v[0], 1'b0, 0);
    chk("lock_after8", 32'(bus0.locked), 32'h1);

    // 2. data capture
    exp_q.push_back('{data: 8'h3C, cnt: 8'd1});
    send_byte(8'h3C, 1'b0, 0);
    chk("cap_valid", 32'(bus0.out_valid), 32'h1);
    chk("cap_data", 32'(bus0.out_data), 32'h3C);
    chk("cap_cnt", 32'(bus0.word_cnt), 32'h1);
`ifdef SERDES_CONT_EN
    chk("cap_locked", 32'(bus0.locked), 32'h1);
`else
    chk("cap_locked", 32'(bus0.locked), 32'h0);
`endif

    // 3. mode check: A5, 3C, C3 without ack, then ack
    do_clr0();
    exp_q.push_back('{data: 8'h3C, cnt: 8'd1});
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h3C, 1'b0, 0);
    send_byte(8'hC3, 1'b0, 0);
`ifdef SERDES_CONT_EN
    chk("mode_overrun", 32'(bus0.overrun), 32'h1);
    chk("mode_locked", 32'(bus0.locked), 32'h1);
`else
    chk("mode_overrun", 32'(bus0.overrun), 32'h0);
    chk("mode_locked", 32'(bus0.locked), 32'h0);
`endif
    chk("mode_data", 32'(bus0.out_data), 32'h3C);
    chk("mode_cnt", 32'(bus0.word_cnt), 32'h1);
    do_ack();
    chk("mode_ack_clears", 32'(bus0.out_valid), 32'h0);

    // 4. gaps and ack coincident with completion
    do_clr0();
    exp_q.push_back('{data: 8'h11, cnt: 8'd1});
    exp_q.push_back('{data: 8'h22, cnt: 8'd2});
    send_byte(8'hA5, 1'b0, 1);
    send_byte(8'h11, 1'b1, 1);
    chk("gap_valid_11", 32'(bus0.out_valid), 32'h1);
    chk("gap_data_11", 32'(bus0.out_data), 32'h11);
`ifndef SERDES_CONT_EN
    send_byte(8'hA5, 1'b0, 1);
`endif
    send_byte(8'h22, 1'b1, 1);
    chk("gap_valid_22", 32'(bus0.out_valid), 32'h1);
    chk("gap_data_22", 32'(bus0.out_data), 32'h22);
    chk("gap_cnt", 32'(bus0.word_cnt), 32'h2);
    chk("gap_overrun", 32'(bus0.overrun), 32'h0);
    do_ack();

    // 5. SYNC=00 must not match the zero reset contents before 8 bits
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    bus1.bit_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus1.bit_valid = 1'b1;
      @(negedge clk);
      bus1.bit_valid = 1'b0;
    end
    chk("zero_sync_7", 32'(bus1.locked), 32'h0);
    bus1.bit_valid = 1'b1;
    @(negedge clk);
    bus1.bit_valid = 1'b0;
    chk("zero_sync_8", 32'(bus1.locked), 32'h1);

    // 6. mid-word sync_clr with simultaneous bit_valid
    do_clr0();
    exp_q.push_back('{data: 8'h3C, cnt: 8'd1});
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h3C, 1'b0, 0);
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h3C, 1'b0, 0);
`ifndef SERDES_CONT_EN
    send_byte(8'hA5, 1'b0, 0);
`endif
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    chk("pre_clr_locked", 32'(bus0.locked), 32'h1);
    chk("pre_clr_overrun", 32'(bus0.overrun), 32'h1);
    clr0 = 1'b1;
    bus0.bit_in = 1'b1;
    bus0.bit_valid = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    bus0.bit_valid = 1'b0;
    chk("clr_flags", {28'h0, bus0.out_valid, bus0.locked, bus0.overrun, 1'b0}, 32'h0);
    chk("clr_cnt", 32'(bus0.word_cnt), 32'h0);
    exp_q.push_back('{data: 8'h77, cnt: 8'd1});
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h77, 1'b1, 0);
    chk("post_clr_data", 32'(bus0.out_data), 32'h77);

    // async reset mid-word discards the partial word
    send_byte(8'hA5, 1'b1, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    #2 Reset = 1'b0;
    #1 chk("async_rst_locked", 32'(bus0.locked), 32'h0);
    chk("async_rst_valid", 32'(bus0.out_valid), 32'h0);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    exp_q.push_back('{data: 8'h5A, cnt: 8'd1});
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h5A, 1'b0, 0);
    chk("post_rst_data", 32'(bus0.out_data), 32'h5A);

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_deser_sync.md
# serial_deser_sync

Frame-synchronising serial-to-parallel converter that consumes the 1-bit stream produced by the flip-flop stage (its `q` output) and assembles it into `WIDTH`-bit words. It hunts for a sync pattern and then shifts in data bits MSB-first. Completed words are presented on a valid/ack handshake with overrun detection. It is the stage directly downstream of the single-bit D flip-flop register.

## Interface
Parameters:
- `WIDTH`, 8: word width and sync-pattern width; legal values are ≥ 2.
- `SYNC`, 8'hA5: sync pattern, compared MSB-first.

Ports:
- `clk`, input, 1: rising-edge clock.
- `Reset`, input, 1: asynchronous, active-low reset.
- `sync_clr`, input, 1: synchronous clear, active-high.
- `bit_in`, input, 1: serial data bit, fed from the flip-flop `q`.
- `bit_valid`, input, 1: `bit_in` is sampled on a rising edge only when this is 1.
- `out_ack`, input, 1: consumer accepts `out_data` in a cycle where `out_valid`=1.
- `out_data`, output, WIDTH: last completed word.
- `out_valid`, output, 1: `out_data` holds an unconsumed word.
- `locked`, output, 1: 1 while in the COLLECT state.
- `overrun`, output, 1: sticky flag; a word was dropped.
- `word_cnt`, output, 8: count of words loaded into `out_data`; wraps modulo 256.

## Operation
- Reset (`Reset`=0, asynchronous) clears all state:
  - state = HUNT, shift register = 0, fill counter = 0, bit counter = 0.
  - `out_data`=0, `out_valid`=0, `locked`=0, `overrun`=0, `word_cnt`=0.
- `sync_clr`=1 on an edge has the same effect as reset, applied synchronously. It has priority over `bit_valid` and `out_ack` in the same cycle.
- Shift rule: on each accepted bit, `sr <= {sr[WIDTH-2:0], bit_in}`, so the first bit received ends up as the MSB.
- HUNT state:
  - Every accepted bit is shifted in and the fill counter increments, saturating at WIDTH.
  - Transition to COLLECT on the edge where the fill counter has already reached WIDTH-1 or more and `{sr[WIDTH-2:0], bit_in} == SYNC`.
  - That transition also clears the bit counter.
  - The fill requirement blocks a false match against the reset contents of the shift register.
- COLLECT state:
  - Each accepted bit is shifted in and the bit counter increments.
  - On the WIDTH-th bit, the completed word is handed to the output stage and the bit counter returns to 0.
  - The next state depends on `SERDES_CONT_EN` (see Configuration).
- Output stage, evaluated on the edge that completes a word:
  - `out_valid`=0, or `out_valid`=1 with `out_ack`=1: load the new word, set `out_valid`=1, increment `word_cnt`.
  - `out_valid`=1 with `out_ack`=0: drop the new word, keep `out_data`, set `overrun`=1, leave `word_cnt` unchanged.
- When no word completes, `out_ack`=1 with `out_valid`=1 clears `out_valid`. `out_data` holds its last value.
- `out_ack` while `out_valid`=0 is ignored.
- `overrun` clears only on reset or `sync_clr`.

## Timing
- Fully synchronous to the `clk` rising edge, except the asynchronous assertion of `Reset`.
- `bit_valid`=0 cycles are fully transparent: state, shift register and counters do not change.
- HUNT to COLLECT: `locked` rises on the edge that samples the last sync bit.
- Word latency: `out_valid` and `out_data` update on the edge that samples the WIDTH-th data bit, i.e. zero extra pipeline cycles.
- Back-to-back operation: one word per WIDTH accepted bits. `out_ack` in the same cycle as a completion sustains `out_valid`=1 with no bubble.
- Asserting `Reset` mid-word discards the partial word; the next sync search starts with an empty fill counter.

## Configuration
- `SERDES_CONT_EN` defined (continuous mode):
  - After each completed word the block stays in COLLECT.
  - Every subsequent WIDTH bits form a word until `sync_clr` or reset.
- `SERDES_CONT_EN` undefined (single-word mode):
  - After each completed word the block returns to HUNT, clearing the fill counter.
  - Each word must be preceded by its own `SYNC`.
  - `locked` falls on the completion edge.

## Test plan
All scenarios use WIDTH=8, SYNC=8'hA5.
1. Reset then lock: drive `Reset`=0 for 3 cycles, then stream 8'hA5 with `bit_valid`=1 → `locked`=1 after the 8th bit. All outputs are 0 during reset.
2. Data capture: stream A5, then 3C → `out_data`=8'h3C, `out_valid`=1, `word_cnt`=1 on the 16th bit edge.
3. Mode check: stream A5, 3C, C3 with no `out_ack` in between, then ack:
   - with `SERDES_CONT_EN`: `overrun`=1 and `out_data` stays 8'h3C;
   - without it: still hunting, so `overrun`=0 and `locked`=0.
4. Gaps and simultaneous ack: with 1-cycle `bit_valid`=0 gaps between bits and `out_ack`=1 on the completion edge, stream A5, 11, 22 (continuous) → `out_valid` stays 1, `out_data` goes 8'h11 then 8'h22, `word_cnt`=2.
5. Reset-state false match: with SYNC=8'h00 and 7 zero bits after reset → `locked`=0; the 8th zero bit → `locked`=1.
6. Mid-word clear: assert `sync_clr` together with `bit_valid` after 4 data bits → HUNT, `locked`=0, `out_valid`=0, `overrun`=0, `word_cnt`=0.
